// File: rtl/gp9001_pkg.sv
// Shared types and helpers for the GP9001 host-side op interface.
package gp9001_pkg;

    localparam int unsigned DEFAULT_AW = 14;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PTR,
        OP_SEL,
        OP_WREG,
        OP_WRAM,
        OP_RDH,
        OP_RDL
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RD_WAIT,
        ACK_HOLD
    } state_e;

    // Fixed-priority pick among simultaneously raised op requests.
    function automatic op_e prio_encode(
        input logic set_ptr,
        input logic sel_reg,
        input logic wr_reg,
        input logic wr_ram,
        input logic rd_ram_h,
        input logic rd_ram_l
    );
        op_e op;
        op = OP_NONE;
        if (set_ptr)       op = OP_PTR;
        else if (sel_reg)  op = OP_SEL;
        else if (wr_reg)   op = OP_WREG;
        else if (wr_ram)   op = OP_WRAM;
        else if (rd_ram_h) op = OP_RDH;
        else if (rd_ram_l) op = OP_RDL;
        return op;
    endfunction

endpackage

// File: rtl/gp9001_host_if.sv
// GP9001 responder for CPU op requests: register index/data, VRAM pointer,
// arbitrated VRAM accesses and a 4-phase ACK handshake.
module gp9001_host_if
    import gp9001_pkg::*;
#(
    parameter int unsigned AW     = DEFAULT_AW,
    parameter int unsigned RD_LAT = 2
) (
    input  logic          CLK96,
    input  logic          RESET96_N,
    input  logic          OP_SELECT_REG,
    input  logic          OP_WRITE_REG,
    input  logic          OP_WRITE_RAM,
    input  logic          OP_READ_RAM_H,
    input  logic          OP_READ_RAM_L,
    input  logic          OP_SET_RAM_PTR,
    input  logic [15:0]   DIN,
    output logic          ACK,
    output logic [15:0]   DOUT,
    output logic          REG_WE,
    output logic [7:0]    REG_IDX,
    output logic [15:0]   REG_DATA,
    input  logic          VRAM_BUSY,
    output logic [AW-1:0] VRAM_ADDR,
    output logic          VRAM_WE,
    output logic          VRAM_RE,
    output logic [15:0]   VRAM_D,
    input  logic [15:0]   VRAM_Q,
    output logic [AW-1:0] RAM_PTR
);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [15:0]        din_q, din_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]      ptr_q, ptr_d;

    logic               ack_d;
    logic [15:0]        dout_d;
    logic               reg_we_d;
    logic [7:0]         reg_idx_d;
    logic [15:0]        reg_data_d;
    logic [AW-1:0]      vram_addr_d;
    logic               vram_we_d;
    logic               vram_re_d;
    logic [15:0]        vram_d_d;

    logic               any_op;
    op_e                req;

    assign any_op  = OP_SET_RAM_PTR | OP_SELECT_REG | OP_WRITE_REG |
                     OP_WRITE_RAM | OP_READ_RAM_H | OP_READ_RAM_L;
    assign req     = prio_encode(OP_SET_RAM_PTR, OP_SELECT_REG, OP_WRITE_REG,
                                 OP_WRITE_RAM, OP_READ_RAM_H, OP_READ_RAM_L);
    assign RAM_PTR = ptr_q;

    // Next-state and next-output logic; strobes default low so they pulse.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        din_d       = din_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        ack_d       = ACK;
        dout_d      = DOUT;
        reg_we_d    = 1'b0;
        reg_idx_d   = REG_IDX;
        reg_data_d  = REG_DATA;
        vram_addr_d = VRAM_ADDR;
        vram_we_d   = 1'b0;
        vram_re_d   = 1'b0;
        vram_d_d    = VRAM_D;

        unique case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                unique case (req)
                    OP_NONE: ;
                    OP_PTR: begin
                        ptr_d   = AW'(DIN);
                        ack_d   = 1'b1;
                        state_d = ACK_HOLD;
                    end
                    OP_SEL: begin
                        reg_idx_d = DIN[7:0];
                        ack_d     = 1'b1;
                        state_d   = ACK_HOLD;
                    end
                    OP_WREG: begin
                        reg_we_d   = 1'b1;
                        reg_data_d = DIN;
                        ack_d      = 1'b1;
                        state_d    = ACK_HOLD;
                    end
                    default: begin
                        op_d    = req;
                        din_d   = DIN;
                        state_d = ACCESS;
                    end
                endcase
            end

            ACCESS: begin
                if (!VRAM_BUSY) begin
                    vram_addr_d = ptr_q;
                    if (op_q == OP_WRAM) begin
                        vram_we_d = 1'b1;
                        vram_d_d  = din_q;
                        ptr_d     = ptr_q + AW'(1);
                        ack_d     = 1'b1;
                        state_d   = ACK_HOLD;
                    end else begin
                        vram_re_d = 1'b1;
                        cnt_d     = CNT_W'(RD_LAT - 1);
                        if (op_q == OP_RDL) ptr_d = ptr_q + AW'(1);
                        state_d   = RD_WAIT;
                    end
                end
            end

            RD_WAIT: begin
                if (cnt_q == '0) begin
                    dout_d  = VRAM_Q;
                    ack_d   = 1'b1;
                    state_d = ACK_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ACK_HOLD: begin
                if (!any_op) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            state_q   <= IDLE;
            op_q      <= OP_NONE;
            din_q     <= '0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            ACK       <= 1'b0;
            DOUT      <= '0;
            REG_WE    <= 1'b0;
            REG_IDX   <= '0;
            REG_DATA  <= '0;
            VRAM_ADDR <= '0;
            VRAM_WE   <= 1'b0;
            VRAM_RE   <= 1'b0;
            VRAM_D    <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            din_q     <= din_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            ACK       <= ack_d;
            DOUT      <= dout_d;
            REG_WE    <= reg_we_d;
            REG_IDX   <= reg_idx_d;
            REG_DATA  <= reg_data_d;
            VRAM_ADDR <= vram_addr_d;
            VRAM_WE   <= vram_we_d;
            VRAM_RE   <= vram_re_d;
            VRAM_D    <= vram_d_d;
        end
    end

endmodule

// File: doc/gp9001_host_if.md
Name: gp9001_host_if

Overview:
- Responder side of the GP9001 CPU op interface: the VDP-side block that services the CPU module's level-held op requests.
- Op requests: select-reg, write-reg, set-ram-ptr, write-ram, read-ram-H, read-ram-L.
- Owns the register index latch and the auto-incrementing VRAM pointer.
- Issues VRAM accesses, arbitrated against the renderer, and returns read data with a 4-phase ACK.
- Sits between the 68k bus glue and the GP9001 VRAM / register bank.

Parameters:
- AW, 14, VRAM word-address width; the pointer wraps modulo 2^AW.
- RD_LAT, 2, VRAM read latency in CLK96 cycles from accepted read to valid VRAM_Q, range 1..7.

Ports:
- CLK96  in  1  system clock
- RESET96_N  in  1  asynchronous active-low reset
- OP_SELECT_REG  in  1  level request: latch register index
- OP_WRITE_REG  in  1  level request: write selected register
- OP_WRITE_RAM  in  1  level request: write VRAM at pointer
- OP_READ_RAM_H  in  1  level request: read VRAM, pointer unchanged
- OP_READ_RAM_L  in  1  level request: read VRAM, pointer post-increment
- OP_SET_RAM_PTR  in  1  level request: load pointer
- DIN  in  16  CPU write data
- ACK  out  1  handshake acknowledge
- DOUT  out  16  read data to CPU
- REG_WE  out  1  one-cycle register write strobe
- REG_IDX  out  8  latched register index
- REG_DATA  out  16  register write data
- VRAM_BUSY  in  1  renderer owns VRAM this cycle; host access must wait
- VRAM_ADDR  out  AW  VRAM address
- VRAM_WE  out  1  VRAM write strobe
- VRAM_RE  out  1  VRAM read strobe
- VRAM_D  out  16  VRAM write data
- VRAM_Q  in  16  VRAM read data
- RAM_PTR  out  AW  current pointer, for debug/verification

Behaviour:
- Clocking and reset:
  - Single clock CLK96; reset is asynchronous, active-low.
  - While RESET96_N is low: ACK=0, DOUT=0, REG_WE=0, REG_IDX=0, REG_DATA=0, VRAM_WE=0, VRAM_RE=0, VRAM_ADDR=0, VRAM_D=0, pointer=0, FSM=IDLE.
  - Reset mid-transaction aborts the transaction; no VRAM or register write completes after reset assertion.
- Handshake (4-phase):
  - A transaction starts in IDLE when any OP_* is high.
  - ACK rises when the op completes and stays high while any OP_* remains high.
  - ACK falls the cycle after all OP_* are sampled low.
  - A new op is accepted only after ACK has fallen.
- Priority when several OP_* are high at the start: SET_RAM_PTR > SELECT_REG > WRITE_REG > WRITE_RAM > READ_RAM_H > READ_RAM_L. Exactly one op executes; the rest are ignored for that transaction.
- FSM states: IDLE, ACCESS, RD_WAIT, ACK_HOLD.
  - IDLE + SET_RAM_PTR: pointer <= DIN[AW-1:0]; go to ACK_HOLD. ACK is asserted on the next cycle (latency 1).
  - IDLE + SELECT_REG: REG_IDX <= DIN[7:0]; go to ACK_HOLD.
  - IDLE + WRITE_REG: REG_WE=1 for exactly one cycle, with REG_DATA=DIN and REG_IDX unchanged; go to ACK_HOLD.
  - IDLE + RAM op: capture op type and DIN; go to ACCESS.
  - ACCESS, VRAM_BUSY=1: stay; no strobe issued.
  - ACCESS, VRAM_BUSY=0, write: VRAM_WE=1 for one cycle with VRAM_ADDR=pointer and VRAM_D=captured DIN; pointer++; go to ACK_HOLD.
  - ACCESS, VRAM_BUSY=0, read: VRAM_RE=1 for one cycle with VRAM_ADDR=pointer; load the latency counter with RD_LAT-1; go to RD_WAIT. READ_RAM_L increments the pointer at issue; READ_RAM_H does not.
  - RD_WAIT: counter counts down. At 0, DOUT <= VRAM_Q; go to ACK_HOLD.
  - ACK_HOLD: ACK=1. When all OP_* are low, ACK=0 next cycle and go to IDLE.
- Pointer arithmetic: AW bits, unsigned; 2^AW-1 increments to 0. No other state changes on wrap.
- VRAM_BUSY is ignored outside ACCESS. A BUSY stall is unbounded.
- DOUT holds its value until the next completed read; it is unaffected by writes.
- Requests dropped before ACK (protocol violation) are completed anyway. ACK then pulses for one cycle and the FSM returns to IDLE.
- Minimum completion latency, op high to ACK high:
  - non-RAM ops: 1 cycle;
  - RAM write: 2 cycles;
  - RAM read: 2+RD_LAT cycles;
  - plus any VRAM_BUSY stall cycles.

Decomposition:
- Shared package gp9001_pkg:
  - op-code enum: OP_NONE, OP_PTR, OP_SEL, OP_WREG, OP_WRAM, OP_RDH, OP_RDL;
  - FSM state enum;
  - default AW;
  - fixed priority-encode function.
- No sub-module is required. The priority encoder is a package function; the latency counter is inline.

Test Plan:
- SET_RAM_PTR with DIN=0x1234, then WRITE_RAM with DIN=0xBEEF, VRAM_BUSY=0 -> VRAM_WE pulse at VRAM_ADDR=0x1234, VRAM_D=0xBEEF; RAM_PTR=0x1235; ACK 2 cycles after op; ACK falls 1 cycle after op drops.
- Preload VRAM[0x0100]=0xA5A5; pointer=0x0100; READ_RAM_H -> DOUT=0xA5A5, RAM_PTR stays 0x0100. Then READ_RAM_L -> DOUT=0xA5A5, RAM_PTR=0x0101. ACK arrives RD_LAT+2 cycles after op.
- Pointer=0x3FFF; WRITE_RAM -> write lands at 0x3FFF; RAM_PTR=0x0000.
- SELECT_REG with DIN=0x0F, then WRITE_REG with DIN=0x00C8 -> single-cycle REG_WE with REG_IDX=0x0F, REG_DATA=0x00C8; no VRAM strobes.
- VRAM_BUSY held high for 5 cycles during WRITE_RAM -> no VRAM_WE until BUSY falls; then one VRAM_WE; ACK follows 1 cycle later. OP_SET_RAM_PTR and OP_WRITE_RAM raised together -> only the pointer loads, no VRAM_WE.
- RESET96_N pulsed low during RD_WAIT -> ACK=0, DOUT=0, RAM_PTR=0 immediately (asynchronous). After release, the next SET_RAM_PTR completes normally.
